// File: rtl/types_pkg.sv
// Shared display types: digit count, cathode byte type and scan FSM states.
package types_pkg;

  localparam int DIGITS = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    S_BLANK,
    S_ON,
    S_OFF
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_tick_counter.sv
// Free-running wrap counter: counts 0..MAX-1 and flags the last count.
module tick_counter #(
  parameter int MAX = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic [$clog2(MAX > 1 ? MAX : 2)-1:0] count,
  output logic                                 wrap
);

  localparam int W = $clog2(MAX > 1 ? MAX : 2);

  assign wrap = (count == W'(MAX - 1));

  // Count up every clock, returning to zero after the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one digit per slot, with a dark blanking
// window at slot start, brightness PWM inside the slot and per-digit blinking.
module seg_scan_ctrl #(
  parameter int DIGITS       = types_pkg::DIGITS,
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGITS*8-1:0]       display,
  input  logic [DIGITS-1:0]         digit_en,
  input  logic [DIGITS-1:0]         blink_en,
  input  logic [3:0]                brightness,
  output logic [DIGITS-1:0]         anode,
  output logic [7:0]                cathode,
  output logic [$clog2(DIGITS)-1:0] cur_digit,
  output logic                      frame_start
);

  import types_pkg::*;

  localparam int SLOT_CYCLES = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int STEP        = (SLOT_CYCLES - BLANK_CYCLES) / 15;
  localparam int CNT_W       = $clog2(SLOT_CYCLES > 1 ? SLOT_CYCLES : 2);
  localparam int BLINK_W     = $clog2(BLINK_CYCLES > 1 ? BLINK_CYCLES : 2);
  localparam int DIG_W       = $clog2(DIGITS);

  // A slot too short for 15 distinct on-times cannot express the brightness range.
  if (STEP < 1) begin : g_step_check
    $error("seg_scan_ctrl: slot too short for 15 brightness steps");
  end

  logic [CNT_W-1:0]   slot_cnt;
  logic               slot_wrap;
  logic [BLINK_W-1:0] blink_cnt_unused;
  logic               blink_wrap;
  logic               blink_phase;
  logic [DIG_W-1:0]   digit;
  scan_state_t        state;
  scan_state_t        state_next;
  byte_t              slot_byte;
  logic [3:0]         bright_lat;
  logic [31:0]        cnt_ext;
  logic [31:0]        on_last;
  logic               lit;
  logic [DIGITS-1:0]  anode_d;
  logic [7:0]         cathode_d;
  logic               frame_start_d;

  tick_counter #(.MAX(SLOT_CYCLES)) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .count (slot_cnt),
    .wrap  (slot_wrap)
  );

  tick_counter #(.MAX(BLINK_CYCLES)) u_blink_counter (
    .clk   (clk),
    .rst   (rst),
    .count (blink_cnt_unused),
    .wrap  (blink_wrap)
  );

  assign cnt_ext = 32'(slot_cnt);
  assign on_last = 32'(BLANK_CYCLES) + 32'(bright_lat) * 32'(STEP) - 32'd1;
  assign lit     = (brightness != 4'd0) && digit_en[digit] &&
                   !(blink_en[digit] && blink_phase);

  // Scan state register; the slot always restarts in blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BLANK;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the output values registered on the next edge.
  always_comb begin
    state_next    = state;
    anode_d       = '1;
    cathode_d     = cathode;
    frame_start_d = 1'b0;
    case (state)
      S_BLANK: begin
        if (cnt_ext == 32'(BLANK_CYCLES - 1)) begin
          state_next = lit ? S_ON : S_OFF;
        end
        frame_start_d = (slot_cnt == '0) && (digit == '0);
      end
      S_ON: begin
        if (cnt_ext == on_last) begin
          state_next = S_OFF;
        end
        anode_d   = ~(DIGITS'(1) << digit);
        cathode_d = slot_byte;
      end
      S_OFF: begin
        state_next = S_OFF;
      end
      default: begin
        state_next = S_BLANK;
      end
    endcase
    if (slot_wrap) begin
      state_next = S_BLANK;
    end
  end

  // Digit sequencing, blink phase, per-slot latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit       <= '0;
      blink_phase <= 1'b0;
      slot_byte   <= 8'hFF;
      bright_lat  <= 4'd0;
      anode       <= '1;
      cathode     <= 8'hFF;
      cur_digit   <= '0;
      frame_start <= 1'b0;
    end else begin
      if (slot_wrap) begin
        digit <= (digit == DIG_W'(DIGITS - 1)) ? '0 : digit + 1'b1;
      end
      if (blink_wrap) begin
        blink_phase <= ~blink_phase;
      end
      if (state == S_BLANK && slot_cnt == '0) begin
        slot_byte <= display[32'(digit) * 8 +: 8];
      end
      if (state == S_BLANK && cnt_ext == 32'(BLANK_CYCLES - 1)) begin
        bright_lat <= brightness;
      end
      anode       <= anode_d;
      cathode     <= cathode_d;
      cur_digit   <= digit;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random
// input changes, compared every cycle against a cycle-count based model.
module tb_seg_scan_ctrl;

  localparam int SLOT  = 20;
  localparam int BLANK = 5;
  localparam int STEP  = 1;
  localparam int BLINK = 400;
  localparam int FRAME = SLOT * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] display = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  blink_en = '0;
  logic [3:0]  brightness = '0;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic [2:0]  cur_digit;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  int unsigned ref_u = 0;
  logic [7:0]  ref_byte = 8'hFF;
  logic [7:0]  ref_cath = 8'hFF;
  logic        ref_lit = 1'b0;
  int          ref_bright = 0;
  logic [7:0]  exp_anode;
  logic [7:0]  exp_cath;
  logic [2:0]  exp_cur;
  logic        exp_fs;

  seg_scan_ctrl #(
    .DIGITS       (8),
    .CLK_HZ       (1600),
    .REFRESH_HZ   (10),
    .BLANK_CYCLES (BLANK),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .display     (display),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .brightness  (brightness),
    .anode       (anode),
    .cathode     (cathode),
    .cur_digit   (cur_digit),
    .frame_start (frame_start)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Expected outputs for the cycle just consumed, derived from the absolute
  // cycle count since reset: slot = u/SLOT, digit = slot%8, blink = (u/BLINK)%2.
  task automatic modelStep();
    int cnt;
    int slot;
    int dig;
    cnt  = int'(ref_u % SLOT);
    slot = int'(ref_u / SLOT);
    dig  = slot % 8;
    if (cnt == 0) ref_byte = display[dig*8 +: 8];
    if (cnt == BLANK - 1) begin
      ref_lit = (brightness != 4'd0) && digit_en[dig] &&
                !(blink_en[dig] && ((ref_u / BLINK) % 2 == 1));
      ref_bright = int'(brightness);
    end
    exp_anode = 8'hFF;
    if (cnt >= BLANK && ref_lit && (cnt - BLANK) < ref_bright * STEP) begin
      exp_anode = ~(8'h01 << dig);
      ref_cath  = ref_byte;
    end
    exp_cath = ref_cath;
    exp_cur  = 3'(dig);
    exp_fs   = (ref_u % FRAME == 0);
    ref_u++;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (anode === exp_anode) else begin
      failures++;
      $error("[TB] FAIL %s anode u=%0d got=%h exp=%h", tag, ref_u, anode, exp_anode);
    end
    checks++;
    assert (cathode === exp_cath) else begin
      failures++;
      $error("[TB] FAIL %s cathode u=%0d got=%h exp=%h", tag, ref_u, cathode, exp_cath);
    end
    checks++;
    assert (cur_digit === exp_cur) else begin
      failures++;
      $error("[TB] FAIL %s cur_digit u=%0d got=%0d exp=%0d", tag, ref_u, cur_digit, exp_cur);
    end
    checks++;
    assert (frame_start === exp_fs) else begin
      failures++;
      $error("[TB] FAIL %s frame_start u=%0d got=%b exp=%b", tag, ref_u, frame_start, exp_fs);
    end
    checks++;
    assert ($countones(~anode) <= 1) else begin
      failures++;
      $error("[TB] FAIL %s anode_onehot u=%0d got=%h exp=at most one low bit", tag, ref_u, anode);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic [7:0] den, input logic [7:0] ben);
    brightness = b;
    digit_en   = den;
    blink_en   = ben;
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      modelStep();
      @(negedge clk);
      checkOutput(tag);
    end
  endtask

  // Called at a falling edge: one reset cycle, then the model restarts at zero.
  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_anode = 8'hFF;
    exp_cath  = 8'hFF;
    exp_cur   = 3'd0;
    exp_fs    = 1'b0;
    checkOutput("reset");
    rst        = 1'b0;
    ref_u      = 0;
    ref_cath   = 8'hFF;
    ref_byte   = 8'hFF;
    ref_lit    = 1'b0;
    ref_bright = 0;
  endtask

  task automatic loadCountingDisplay();
    for (int i = 0; i < 8; i++) display[i*8 +: 8] = 8'(i + 1);
  endtask

  initial begin
    int n;
    $display("[TB] start");

    // Full brightness, all digits enabled, byte i = i+1.
    loadCountingDisplay();
    applyStimulus(4'd15, 8'hFF, 8'h00);
    doReset();
    runCycles(2 * FRAME, "full_bright");

    // Partial duty, then fully dark.
    applyStimulus(4'd4, 8'hFF, 8'h00);
    runCycles(FRAME + 20, "bright4");
    applyStimulus(4'd0, 8'hFF, 8'h00);
    runCycles(FRAME + 20, "bright0");

    // Digit 2 disabled.
    applyStimulus(4'd15, 8'hFB, 8'h00);
    runCycles(FRAME + 20, "digit_en");

    // Digit 7 blinking across several blink half-periods.
    applyStimulus(4'd15, 8'hFF, 8'h80);
    runCycles(3 * BLINK + 100, "blink");

    // Display change in the middle of slot 1 only shows next frame.
    loadCountingDisplay();
    applyStimulus(4'd15, 8'hFF, 8'h00);
    doReset();
    runCycles(SLOT + 8, "tear_pre");
    display[15:8] = 8'hAA;
    runCycles(FRAME + 20, "tear_post");

    // Reset in the lit part of slot 5.
    n = int'((5 * SLOT + 10 + FRAME - int'(ref_u % FRAME)) % FRAME);
    runCycles(n, "pre_reset");
    doReset();
    runCycles(2 * SLOT, "post_reset");

    // Random inputs applied at random points, with occasional resets.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) doReset();
      display = {$urandom, $urandom};
      applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      runCycles(int'($urandom_range(1, 80)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display. Takes the flattened per-digit cathode vector produced by the calculator display path and drives one shared cathode bus plus per-digit anodes, one digit at a time. It adds anti-ghosting blanking, 16-level brightness PWM and per-digit blinking, for example to flash the digit under edit. Sits between the display-formatting logic and the board pins.

Parameters:
DIGITS, types_pkg::DIGITS (8), number of digits scanned.
CLK_HZ, 100_000_000, clk frequency.
REFRESH_HZ, 1000, full-frame refresh rate.
BLANK_CYCLES, 64, all-anodes-off dead time at the start of each digit slot.
BLINK_CYCLES, 25_000_000, clk cycles per blink half-period.
Derived localparams:
- SLOT_CYCLES = CLK_HZ/(REFRESH_HZ*DIGITS).
- STEP = (SLOT_CYCLES-BLANK_CYCLES)/15.
- Elaboration error if STEP < 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
display  input  DIGITS*8  flattened cathode bytes, digit i at [i*8+:8], passed through unmodified
digit_en  input  DIGITS  1 = digit may light; 0 = slot kept dark
blink_en  input  DIGITS  1 = digit dark during blink-off phase
brightness  input  4  duty level 0..15
anode  output  DIGITS  active-low digit enables, one-hot-low or all-ones
cathode  output  8  byte of the currently scanned digit
cur_digit  output  $clog2(DIGITS)  index of the current slot
frame_start  output  1  one-cycle pulse on entry to slot 0

Behaviour:
Interface: one clock `clk`; reset `rst` is synchronous and active-high.

Reset values (all outputs registered):
- anode = all ones; cathode = 8'hFF; cur_digit = 0; frame_start = 0.
- Internal state = S_BLANK, slot counter = 0, blink counter = 0, blink_phase = 0.

Slot counter:
- Runs 0..SLOT_CYCLES-1, then wraps.
- At wrap, cur_digit increments, with DIGITS-1 wrapping to 0.

FSM, evaluated per slot:
- S_BLANK, counter 0..BLANK_CYCLES-1:
  - anode is all ones.
  - On the first cycle, latch display[cur_digit*8+:8] into a slot register. This prevents mid-slot tearing; display changes appear from the next slot.
  - Exit: to S_ON if the lit condition holds, else to S_OFF.
  - Lit condition: brightness != 0 && digit_en[cur_digit] && !(blink_en[cur_digit] && blink_phase). brightness, digit_en and blink_en are all sampled at this transition.
- S_ON, for brightness*STEP cycles:
  - anode[cur_digit] = 0, others 1; cathode = latched byte.
  - Then go to S_OFF.
  - brightness = 15 keeps S_ON until slot end, with the remainder (SLOT_CYCLES-BLANK_CYCLES) mod 15 cycles spent in S_OFF.
- S_OFF, until slot end: anode all ones, cathode holds its last value.
- Next slot returns to S_BLANK.

Timing and events:
- Anode edges are registered, so outputs lag state by 1 cycle, identically for all transitions.
- frame_start pulses in the first cycle (registered) of S_BLANK for slot 0.
- Blink counter is free-running: 0..BLINK_CYCLES-1, toggling blink_phase at wrap. It is independent of the scan and changes only at slot boundaries as seen by the FSM.
- Input changes mid-slot never shorten or extend the current slot.
- The anode output never has more than one 0 bit in any cycle.
- rst asserted mid-slot: the next cycle shows reset values and the scan restarts at digit 0 with a full S_BLANK.

Decomposition:
- types_pkg: add scan_state_t enum {S_BLANK, S_ON, S_OFF}.
- DIGITS and byte_t are reused from types_pkg.
- One sub-module: tick_counter #(MAX), a wrap counter with `wrap` output. It is instantiated twice, as the slot counter and as the blink counter.

Test Plan:
Test configuration for all scenarios: CLK_HZ=1600, REFRESH_HZ=10, DIGITS=8, BLANK_CYCLES=5, BLINK_CYCLES=400, giving SLOT_CYCLES=20 and STEP=1.
1. Reset, brightness=15, digit_en=8'hFF, display byte i = i+1 -> anode all ones for 5 cycles, then anode = 8'hFE and cathode = 8'h01 for 15 cycles. Digits then cycle in order, and frame_start pulses every 160 cycles.
2. brightness=4 -> each slot has 5 blank cycles, 4 lit cycles and 11 off cycles. brightness=0 -> anode stays 8'hFF continuously.
3. digit_en=8'b1111_1011 -> digit 2 is dark for its whole 20-cycle slot, with no change to the slot period or order.
4. blink_en=8'h80, brightness=15 -> digit 7 is lit in frames during blink_phase=0 and dark in frames during blink_phase=1, switching every 400 cycles. Other digits are unaffected.
5. Change display[15:8] from 8'h02 to 8'hAA at cycle 8 of slot 1 -> cathode stays 8'h02 for that slot and shows 8'hAA in the next frame's slot 1.
6. Assert rst for 1 cycle in S_ON of slot 5 -> the next cycle has anode=8'hFF, cur_digit=0 and cathode=8'hFF, followed by a full 5-cycle blank and then digit 0. Check the one-hot-low anode assertion throughout.
